ins_ram_loader: RTL and testbench

Stream-to-memory loader that fills an instruction RAM (registered-address, one-cycle write, read data one cycle after address) from a byte stream, typically the UART receiver. It accepts a length byte, that many program words, and a checksum byte. It then reads the whole image back through the same RAM port to confirm it. It sits between the serial front end and the instruction/data RAMs of each core and holds the cores idle until `done`.

---
 rtl/details.sv | 20 ++
 rtl/ins_ram_loader.sv | 129 ++++++++++++
 tb/tb_ins_ram_loader.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/details.sv
// Shared types for the core-programming front end: loader FSM states and
// the descriptor of a loaded memory image.
package details;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_VERIFY,
        S_DONE
    } loader_state_t;

    // Length (up to DEPTH words, hence the extra bit) and checksum of an image.
    typedef struct packed {
        logic [8:0] len;
        logic [7:0] sum;
    } mem_init_t;

endpackage

// File: rtl/ins_ram_loader.sv
// Stream-to-RAM loader: takes a length byte, N words and a checksum byte,
// writes the words into RAM, then reads the image back to confirm it.
module ins_ram_loader
    import details::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  start,
    input  logic [WIDTH-1:0]      byteIn,
    input  logic                  byteValid,
    output logic                  byteReady,
    output logic                  wrEn,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      dataOut,
    input  logic [WIDTH-1:0]      dataIn,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [WIDTH-1:0]      checksum
);

    localparam int CW = ADDR_WIDTH + 1;

    loader_state_t   state, state_nxt;
    logic [CW-1:0]    len, wr_cnt, rd_cnt, wr_cnt_inc, rd_cnt_inc;
    logic [WIDTH-1:0] wr_sum, rd_sum, exp_sum, rd_sum_nxt;
    logic             fire, len_zero, len_over, verify_last;

    always_comb begin
        byteReady   = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
        busy        = !((state == S_IDLE) || (state == S_DONE));
        done        = (state == S_DONE);
        fire        = byteValid && byteReady;
        wr_cnt_inc  = wr_cnt + CW'(1);
        rd_cnt_inc  = rd_cnt + CW'(1);
        len_zero    = (byteIn == '0);
        len_over    = 32'(byteIn) > 32'(DEPTH);
        verify_last = (rd_cnt == len);
        // Read data trails the address by one cycle, so VERIFY cycle 0 has no sample.
        rd_sum_nxt  = (rd_cnt != '0) ? rd_sum + dataIn : rd_sum;

        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_LEN;
            S_LEN: begin
                if (fire) begin
                    if (len_over)      state_nxt = S_DONE;
                    else if (len_zero) state_nxt = S_CSUM;
                    else               state_nxt = S_DATA;
                end
            end
            S_DATA:   if (fire && (wr_cnt_inc == len)) state_nxt = S_CSUM;
            S_CSUM:   if (fire) state_nxt = S_VERIFY;
            S_VERIFY: if (verify_last) state_nxt = S_DONE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            len      <= '0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            wr_sum   <= '0;
            rd_sum   <= '0;
            exp_sum  <= '0;
            wrEn     <= 1'b0;
            addr     <= '0;
            dataOut  <= '0;
            error    <= 1'b0;
            checksum <= '0;
        end else begin
            wrEn <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        wr_cnt <= '0;
                        rd_cnt <= '0;
                        wr_sum <= '0;
                        rd_sum <= '0;
                        error  <= 1'b0;
                    end
                end
                S_LEN: begin
                    if (fire) begin
                        len <= CW'(byteIn);
                        if (len_over) error <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (fire) begin
                        wrEn    <= 1'b1;
                        addr    <= wr_cnt[ADDR_WIDTH-1:0];
                        dataOut <= byteIn;
                        wr_sum  <= wr_sum + byteIn;
                        wr_cnt  <= wr_cnt_inc;
                    end
                end
                S_CSUM: begin
                    if (fire) begin
                        exp_sum <= byteIn;
                        rd_cnt  <= '0;
                        addr    <= '0;
                    end
                end
                S_VERIFY: begin
                    rd_sum <= rd_sum_nxt;
                    rd_cnt <= rd_cnt_inc;
                    if (rd_cnt_inc < len) addr <= rd_cnt_inc[ADDR_WIDTH-1:0];
                    if (verify_last) begin
                        error    <= (rd_sum_nxt != exp_sum) || (wr_sum != exp_sum);
                        checksum <= rd_sum_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ins_ram_loader.sv
// Directed plus randomized loads against a simple image/checksum reference model.
module tb_ins_ram_loader;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst_n, start, byte_valid, scramble;
    logic [WIDTH-1:0] byte_in, data_out, data_in, checksum;
    logic [AW-1:0]    addr;
    logic             byte_ready, wr_en, busy, done, error;

    always #5 clk = ~clk;

    ins_ram_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstN(rst_n), .start(start), .byteIn(byte_in), .byteValid(byte_valid),
        .byteReady(byte_ready), .wrEn(wr_en), .addr(addr), .dataOut(data_out),
        .dataIn(data_in), .busy(busy), .done(done), .error(error), .checksum(checksum)
    );

    // Registered-address RAM; scramble fills it with junk so stale data cannot mask missing writes.
    logic [WIDTH-1:0] ram [0:DEPTH-1];
    logic [AW-1:0]    ram_addr_q;
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= 8'($urandom);
        end else if (wr_en) begin
            ram[addr] <= data_out;
        end
        ram_addr_q <= addr;
    end
    assign data_in = ram[ram_addr_q];

    int            wr_count = 0, verify_cycles = 0, wr_in_verify = 0;
    logic [AW-1:0] wq_addr [$];
    logic [7:0]    wq_data [$];
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                wr_count++;
                wq_addr.push_back(addr);
                wq_data.push_back(data_out);
            end
            if (busy && !byte_ready) begin
                verify_cycles++;
                if (wr_en) wr_in_verify++;
            end
        end
    end

    int         checks = 0, passes = 0;
    logic [7:0] img [0:255];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] img_sum(input int n);
        logic [7:0] s = '0;
        for (int i = 0; i < n; i++) s += img[i];
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b, input int gap);
        int t = 0;
        byte_valid = 1'b0;
        repeat (gap) begin
            byte_in = 8'($urandom);
            step();
        end
        byte_valid = 1'b1;
        byte_in    = b;
        while (!byte_ready && t < 50) begin
            step();
            t++;
        end
        check({tag, "_ready_wait"}, 32'(t < 50), 32'(1));
        step();
        byte_valid = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_byteReady"}, 32'(byte_ready), 32'(0));
        check({tag, "_wrEn"},      32'(wr_en),      32'(0));
        check({tag, "_addr"},      32'(addr),       32'(0));
        check({tag, "_dataOut"},   32'(data_out),   32'(0));
        check({tag, "_busy"},      32'(busy),       32'(0));
        check({tag, "_done"},      32'(done),       32'(0));
        check({tag, "_error"},     32'(error),      32'(0));
        check({tag, "_checksum"},  32'(checksum),   32'(0));
    endtask

    task automatic pulse_start(input string tag);
        bit was_done = done;
        start = 1'b1;
        step();
        start = 1'b0;
        if (was_done) check({tag, "_done_drop"}, 32'(done), 32'(0));
        check({tag, "_busy_after_start"}, 32'(busy), 32'(1));
    endtask

    task automatic load(input string tag, input int n, input logic [7:0] csum_byte,
                        input int max_gap, input bit busy_start);
        bit         len_err = (n > DEPTH);
        logic [7:0] sum = img_sum(n);
        int         wbase, vbase, wvbase, nw, bad, t;

        scramble = 1'b1;
        step();
        scramble = 1'b0;
        wbase  = wr_count;
        vbase  = verify_cycles;
        wvbase = wr_in_verify;

        pulse_start(tag);
        send_byte(tag, 8'(n), $urandom_range(0, max_gap));
        if (!len_err) begin
            for (int i = 0; i < n; i++) begin
                if (busy_start && i == 2) begin
                    start = 1'b1;
                    step();
                    start = 1'b0;
                    check({tag, "_ignored_start"}, 32'(busy), 32'(1));
                end
                send_byte(tag, img[i], $urandom_range(0, max_gap));
            end
            send_byte(tag, csum_byte, $urandom_range(0, max_gap));
        end

        t = 0;
        while (!done && t < 200) begin
            step();
            t++;
        end
        check({tag, "_done"}, 32'(done), 32'(1));
        check({tag, "_busy_idle"}, 32'(busy), 32'(0));
        check({tag, "_error"}, 32'(error), 32'(len_err || (csum_byte != sum)));
        if (!len_err) check({tag, "_checksum"}, 32'(checksum), 32'(sum));

        nw = wr_count - wbase;
        check({tag, "_writes"}, 32'(nw), 32'(len_err ? 0 : n));
        bad = 0;
        for (int k = 0; k < nw; k++) begin
            if (k >= n || len_err) bad++;
            else if (wq_addr[wbase+k] !== AW'(k) || wq_data[wbase+k] !== img[k]) bad++;
        end
        if (!len_err)
            for (int i = 0; i < n; i++) if (ram[i] !== img[i]) bad++;
        check({tag, "_write_data"}, 32'(bad), 32'(0));
        check({tag, "_verify_len"}, 32'(verify_cycles - vbase), 32'(len_err ? 0 : n + 1));
        check({tag, "_wr_in_verify"}, 32'(wr_in_verify - wvbase), 32'(0));
    endtask

    initial begin
        int n;
        logic [7:0] cs;

        rst_n      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = '0;
        scramble   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 4; i++) img[i] = 8'(i + 1);
        load("basic", 4, 8'h0A, 0, 1'b0);
        load("bad_csum", 4, 8'h0B, 0, 1'b0);

        img[0] = 8'hFF;
        img[1] = 8'h02;
        load("wrap_gaps", 2, 8'h01, 3, 1'b0);
        load("empty", 0, 8'h00, 2, 1'b0);

        for (int i = 0; i < 4; i++) img[i] = 8'($urandom);
        load("busy_start", 4, img_sum(4), 1, 1'b1);

        // Abandon a load after two of four data bytes.
        pulse_start("mid_rst");
        send_byte("mid_rst", 8'd4, 0);
        send_byte("mid_rst", img[0], 0);
        send_byte("mid_rst", img[1], 0);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_rst");
        step();
        rst_n = 1'b1;
        step();
        load("post_rst", 4, img_sum(4), 1, 1'b0);

        for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
        load("full_depth", DEPTH, img_sum(DEPTH), 1, 1'b0);
        load("over_depth", DEPTH + 1, 8'h00, 0, 1'b0);
        load("over_255", 255, 8'h00, 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(0, DEPTH);
            for (int i = 0; i < n; i++) img[i] = 8'($urandom);
            cs = img_sum(n);
            if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
            load($sformatf("rand%0d", r), n, cs, 3, r[0]);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
